// File: rtl/game_key_if.sv
// Scan-code byte stream from the PS/2 receiver into the key controller.
interface game_key_if;
    logic [7:0] code;
    logic       code_valid;

    modport master (output code, output code_valid);
    modport slave  (input  code, input  code_valid);
endinterface

// File: rtl/game_key_ctrl.sv
// PS/2 scan-code interpreter: tracks play-key make/break state and drives the game status FSM.
// Optional KEY_TIMEOUT_EN macro discards a dangling E0/F0 prefix after PREFIX_TIMEOUT idle cycles.
module game_key_ctrl #(
    parameter int unsigned                NUM_KEYS       = 4,
    parameter logic [8*NUM_KEYS-1:0]      KEY_CODES      = {8'h72, 8'h75, 8'h6B, 8'h74},
    parameter logic [7:0]                 START_CODE     = 8'h29,
    parameter logic [7:0]                 PAUSE_CODE     = 8'h4D,
    parameter logic [7:0]                 QUIT_CODE      = 8'h76,
    parameter int unsigned                PREFIX_TIMEOUT = 2500000
) (
    input  logic                clk,
    input  logic                clr,
    game_key_if.slave           kb,
    input  logic                game_over,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [1:0]          status,
    output logic                status_change
);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    if (NUM_KEYS < 1 || NUM_KEYS > 16 || PREFIX_TIMEOUT < 1) begin : g_bad_param
        $error("game_key_ctrl: NUM_KEYS or PREFIX_TIMEOUT out of range");
    end

    typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK} parse_e;
    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_ACT   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_TERM  = 2'b11
    } status_e;

    parse_e                parse_q, parse_d;
    status_e               status_q, status_d;
    logic [NUM_KEYS-1:0]   key_held_q, key_held_d;
    logic [NUM_KEYS-1:0]   key_press_q, key_press_d;
    logic                  status_change_q, status_change_d;
    logic                  start_held_q, start_held_d;
    logic                  pause_held_q, pause_held_d;
    logic                  quit_held_q, quit_held_d;

    logic make_ev, brk_ev, byte_ev;
    logic start_first, pause_first, quit_first;

`ifdef KEY_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(PREFIX_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        parse_d         = parse_q;
        status_d        = status_q;
        key_held_d      = key_held_q;
        key_press_d     = '0;
        start_held_d    = start_held_q;
        pause_held_d    = pause_held_q;
        quit_held_d     = quit_held_q;

        byte_ev = kb.code_valid && (kb.code != CODE_EXT) && (kb.code != CODE_BRK);
        make_ev = byte_ev && (parse_q != P_BRK);
        brk_ev  = byte_ev && (parse_q == P_BRK);

        // Prefix parser; E0 is swallowed so extended and plain codes match alike
        if (kb.code_valid) begin
            if (kb.code == CODE_BRK)      parse_d = P_BRK;
            else if (kb.code == CODE_EXT) parse_d = (parse_q == P_BRK) ? P_BRK : P_EXT;
            else                          parse_d = P_IDLE;
        end

`ifdef KEY_TIMEOUT_EN
        // Expiry lands on the edge where the count would reach PREFIX_TIMEOUT
        cnt_d = '0;
        if (!kb.code_valid && parse_q != P_IDLE) begin
            if (cnt_q == CNT_W'(PREFIX_TIMEOUT - 1)) parse_d = P_IDLE;
            else                                     cnt_d   = cnt_q + CNT_W'(1);
        end
`endif

        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (kb.code == KEY_CODES[8*i +: 8]) begin
                if (make_ev) begin
                    key_held_d[i]  = 1'b1;
                    key_press_d[i] = !key_held_q[i] && (status_q == ST_ACT);
                end else if (brk_ev) begin
                    key_held_d[i]  = 1'b0;
                end
            end
        end

        start_first = make_ev && (kb.code == START_CODE) && !start_held_q;
        pause_first = make_ev && (kb.code == PAUSE_CODE) && !pause_held_q;
        quit_first  = make_ev && (kb.code == QUIT_CODE)  && !quit_held_q;

        if (make_ev && kb.code == START_CODE)     start_held_d = 1'b1;
        else if (brk_ev && kb.code == START_CODE) start_held_d = 1'b0;
        if (make_ev && kb.code == PAUSE_CODE)     pause_held_d = 1'b1;
        else if (brk_ev && kb.code == PAUSE_CODE) pause_held_d = 1'b0;
        if (make_ev && kb.code == QUIT_CODE)      quit_held_d  = 1'b1;
        else if (brk_ev && kb.code == QUIT_CODE)  quit_held_d  = 1'b0;

        // Priority: game_over, then quit, then start/pause
        if (game_over && status_q == ST_ACT) begin
            status_d = ST_TERM;
        end else if (quit_first && (status_q == ST_ACT || status_q == ST_PAUSE)) begin
            status_d = ST_TERM;
        end else begin
            case (status_q)
                ST_LOAD:  if (start_first)                status_d = ST_ACT;
                ST_ACT:   if (pause_first)                status_d = ST_PAUSE;
                ST_PAUSE: if (pause_first || start_first) status_d = ST_ACT;
                ST_TERM:  if (start_first)                status_d = ST_LOAD;
                default:                                  status_d = ST_LOAD;
            endcase
        end

        // A fresh game starts with no keys or control keys considered held
        if (status_d == ST_LOAD && status_q != ST_LOAD) begin
            key_held_d   = '0;
            start_held_d = 1'b0;
            pause_held_d = 1'b0;
            quit_held_d  = 1'b0;
        end

        status_change_d = (status_d != status_q);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            parse_q         <= P_IDLE;
            status_q        <= ST_LOAD;
            key_held_q      <= '0;
            key_press_q     <= '0;
            status_change_q <= 1'b0;
            start_held_q    <= 1'b0;
            pause_held_q    <= 1'b0;
            quit_held_q     <= 1'b0;
`ifdef KEY_TIMEOUT_EN
            cnt_q           <= '0;
`endif
        end else begin
            parse_q         <= parse_d;
            status_q        <= status_d;
            key_held_q      <= key_held_d;
            key_press_q     <= key_press_d;
            status_change_q <= status_change_d;
            start_held_q    <= start_held_d;
            pause_held_q    <= pause_held_d;
            quit_held_q     <= quit_held_d;
`ifdef KEY_TIMEOUT_EN
            cnt_q           <= cnt_d;
`endif
        end
    end

    assign key_held      = key_held_q;
    assign key_press     = key_press_q;
    assign status        = status_q;
    assign status_change = status_change_q;

endmodule
